context_register_file: RTL and testbench
========================================

Name: context_register_file

Overview:
Parametrised successor to the CPU register file. It provides:
- NUM_GPR general registers plus ACC, DBAR/DOFF, IBAR/IOFF and STATUS.
- Two mux-based read ports; the internal tristates are removed.
- Post-modify auto-increment/decrement of the DMAR and IMAR pointers, with carry/borrow between offset and base.
- A shadow bank with a sequenced context save/restore engine for interrupt entry and exit.

It sits between the control unit, the ALU operand buses and the memory address generators.

Parameters:
- DATA_W, 8, register width.
- I_ADDR_WIDTH, 12, IMAR width. Must satisfy DATA_W < I_ADDR_WIDTH <= 2*DATA_W.
- D_ADDR_WIDTH, 12, DMAR width. Same constraint as I_ADDR_WIDTH.
- NUM_GPR, 8, general registers, 1..8, mapped to addresses 0..NUM_GPR-1.
- REG_ADDR_WIDTH, 4, register address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- acc_out  out  DATA_W  live ACC value.
- acc_in  in  DATA_W  external ACC write data.
- acc_src_sel  in  1  ACC write source: 0 = acc_in, 1 = rd_data_b.
- acc_write_enable  in  1  write ACC this cycle.
- put_enable  in  1  write ACC to reg[put_addr].
- put_addr  in  REG_ADDR_WIDTH  PUT target.
- rd_addr_a / rd_addr_b  in  REG_ADDR_WIDTH  read addresses.
- rd_data_a / rd_data_b  out  DATA_W  read data.
- status_write_enable  in  1  latch flags.
- flags_in  in  4  {overflow, carry, negative, zero}.
- dmar_inc / dmar_dec  in  1  post-modify DMAR by +1 / -1.
- imar_inc  in  1  post-modify IMAR by +1.
- ctx_save / ctx_restore  in  1  start a context save / restore.
- ctx_busy  out  1  engine active.
- ctx_done  out  1  one-cycle completion pulse.
- dmar  out  D_ADDR_WIDTH  {dbar, doff}.
- imar  out  I_ADDR_WIDTH  {ibar, ioff}.

Behaviour:
- **Reset:** asserting reset_n low asynchronously clears all live registers, all shadow registers and the FSM (state IDLE). All outputs read 0 and ctx_busy=ctx_done=0. Reset mid-save or mid-restore aborts the operation with no ctx_done pulse.
- **Address map:** 0-7 GPR, 8 ACC, 9 DBAR, 10 DOFF, 11 IBAR, 12 IOFF, 13 STATUS. The valid GPR range is addr < NUM_GPR.
- **Unmapped reads:** return 0. Narrow base registers read zero-extended.
- **Reads:** combinational, zero latency.
- **Write-through bypass:** if put_enable and put_addr==rd_addr_x (writable target), rd_data_x returns acc in the same cycle.
- **ACC write:** acc <= acc_src_sel ? rd_data_b : acc_in on the clock edge.
- **PUT:** writes acc to GPR, DBAR, DOFF, IBAR, IOFF or STATUS[DATA_W-1:4].
  - Base registers take the low (ADDR_WIDTH-DATA_W) bits of acc.
  - PUT to ACC or to an unmapped address is a no-op.
- **STATUS:** status_write_enable loads bits 3:0 from flags_in. A simultaneous PUT to STATUS updates only bits DATA_W-1:4; the flags win bits 3:0.
- **DMAR step:**
  - dmar_inc alone: {dbar,doff} <= +1, wrapping all-ones to 0.
  - dmar_dec alone: -1, wrapping 0 to all-ones.
  - Both asserted: no-op.
  - The step uses pre-edge values. A PUT to DBAR or DOFF in the same cycle wins over the step, and the step is dropped.
- **IMAR step:** imar_inc follows the same rules against PUT to IBAR/IOFF.
- **Context FSM states:** IDLE, SAVE, RESTORE.
  - IDLE -> SAVE on ctx_save. IDLE -> RESTORE on ctx_restore. If both are asserted, save wins.
  - Requests are ignored while busy.
  - The engine sequences index 0..CTX_LEN-1, with CTX_LEN = NUM_GPR+6. Order: GPRs, ACC, DBAR, DOFF, IBAR, IOFF, STATUS. One register is copied per cycle (live->shadow for SAVE, shadow->live for RESTORE).
  - ctx_busy is high from the cycle after the request through the cycle of the last copy.
  - ctx_done pulses for 1 cycle on the cycle after the last copy, with ctx_busy already low. The FSM then returns to IDLE.
  - Latency is request to ctx_done = CTX_LEN+1 cycles.
- **While ctx_busy:** acc_write_enable, put_enable, status_write_enable and all step inputs are ignored. Reads return live values, which may be partially restored.

Decomposition:
- **register_file_pkg** holds:
  - the reg_addr_t enum (REG_R0..REG_R7, REG_ACC, REG_DBAR, REG_DOFF, REG_IBAR, REG_IOFF, REG_STATUS);
  - flag bit indices (ZERO_FLAG=0, NEGATIVE_FLAG=1, CARRY_FLAG=2, OVERFLOW_FLAG=3);
  - ctx_state_t {CTX_IDLE, CTX_SAVE, CTX_RESTORE};
  - CTX_EXTRA=6.
- **Sub-module addr_pointer** (parameters BASE_W, OFF_W): holds base/offset registers, PUT loads, inc/dec with carry/borrow and wrap. It is instantiated for DMAR and IMAR; the IMAR instance has dec tied to 0.

Test Plan:
1. Reset then read all 16 addresses on both ports -> all 0; dmar=0, imar=0, ctx_busy=0.
2. acc_in=0x5A with write enable, then PUT to R3 with rd_addr_a=3 in the same cycle -> rd_data_a=0x5A that cycle (bypass), R3=0x5A after the edge. A PUT to ACC leaves acc unchanged.
3. DBAR=0x0, DOFF=0xFF, dmar_inc -> dmar=0x100. From dmar=0xFFF, inc -> 0x000. From 0x000, dec -> 0xFFF. Inc with a same-cycle PUT DOFF=0x10 -> dmar=0x010.
4. status_write_enable with flags_in=4'b1010 plus a same-cycle PUT STATUS with acc=0xF5 -> status=0xFA.
5. Load R0..R7=1..8 and ACC=0x33, ctx_save -> busy for 14 cycles, then ctx_done; overwrite all registers, ctx_restore -> original values restored. A PUT issued while busy is ignored.
6. Assert reset_n low mid-restore at index 5 -> all registers 0, no ctx_done. ctx_save and ctx_restore in the same cycle -> SAVE runs.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types for the context register file: register address map,
// STATUS flag positions and context save/restore engine states.
package register_file_pkg;

  typedef enum logic [3:0] {
    REG_R0     = 4'd0,
    REG_R1     = 4'd1,
    REG_R2     = 4'd2,
    REG_R3     = 4'd3,
    REG_R4     = 4'd4,
    REG_R5     = 4'd5,
    REG_R6     = 4'd6,
    REG_R7     = 4'd7,
    REG_ACC    = 4'd8,
    REG_DBAR   = 4'd9,
    REG_DOFF   = 4'd10,
    REG_IBAR   = 4'd11,
    REG_IOFF   = 4'd12,
    REG_STATUS = 4'd13
  } reg_addr_t;

  localparam int ZERO_FLAG     = 0;
  localparam int NEGATIVE_FLAG = 1;
  localparam int CARRY_FLAG    = 2;
  localparam int OVERFLOW_FLAG = 3;

  typedef enum logic [1:0] {
    CTX_IDLE    = 2'd0,
    CTX_SAVE    = 2'd1,
    CTX_RESTORE = 2'd2
  } ctx_state_t;

  // Non-GPR registers carried by a context: ACC, DBAR, DOFF, IBAR, IOFF, STATUS.
  localparam int CTX_EXTRA = 6;

endpackage

// File: rtl/addr_pointer.sv
// Base/offset memory address pointer with independent field loads and a
// post-modify +1/-1 step that carries or borrows from offset into base.
module addr_pointer #(
  parameter int BASE_W = 4,
  parameter int OFF_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_base_i,
  input  logic [BASE_W-1:0] base_i,
  input  logic              load_off_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [BASE_W-1:0] base_o,
  output logic [OFF_W-1:0]  off_o
);

  localparam int PTR_W = BASE_W + OFF_W;

  logic [BASE_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [PTR_W-1:0]  ptr_step;

  always_comb begin
    ptr_step = {base_q, off_q};
    if (inc_i && !dec_i) begin
      ptr_step = ptr_step + PTR_W'(1);
    end else if (dec_i && !inc_i) begin
      ptr_step = ptr_step - PTR_W'(1);
    end
    base_d = ptr_step[PTR_W-1:OFF_W];
    off_d  = ptr_step[OFF_W-1:0];
    // Any explicit load cancels the whole step; the unloaded field holds.
    if (load_base_i || load_off_i) begin
      base_d = load_base_i ? base_i : base_q;
      off_d  = load_off_i  ? off_i  : off_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      off_q  <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
    end
  end

  assign base_o = base_q;
  assign off_o  = off_q;

endmodule

// File: rtl/context_register_file.sv
// CPU register file with GPRs, ACC, DMAR/IMAR pointers, STATUS, two
// combinational read ports and a one-register-per-cycle shadow context engine.
module context_register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int I_ADDR_WIDTH   = 12,
  parameter int D_ADDR_WIDTH   = 12,
  parameter int NUM_GPR        = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic [DATA_W-1:0]         acc_out,
  input  logic [DATA_W-1:0]         acc_in,
  input  logic                      acc_src_sel,
  input  logic                      acc_write_enable,
  input  logic                      put_enable,
  input  logic [REG_ADDR_WIDTH-1:0] put_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_W-1:0]         rd_data_a,
  output logic [DATA_W-1:0]         rd_data_b,
  input  logic                      status_write_enable,
  input  logic [3:0]                flags_in,
  input  logic                      dmar_inc,
  input  logic                      dmar_dec,
  input  logic                      imar_inc,
  input  logic                      ctx_save,
  input  logic                      ctx_restore,
  output logic                      ctx_busy,
  output logic                      ctx_done,
  output logic [D_ADDR_WIDTH-1:0]   dmar,
  output logic [I_ADDR_WIDTH-1:0]   imar
);

  localparam int CTX_LEN     = NUM_GPR + CTX_EXTRA;
  localparam int IDX_W       = $clog2(CTX_LEN);
  localparam int NUM_ADDR    = 2 ** REG_ADDR_WIDTH;
  localparam int DB_W        = D_ADDR_WIDTH - DATA_W;
  localparam int IB_W        = I_ADDR_WIDTH - DATA_W;
  localparam int ADDR_ACC    = int'(REG_ACC);
  localparam int ADDR_DBAR   = int'(REG_DBAR);
  localparam int ADDR_DOFF   = int'(REG_DOFF);
  localparam int ADDR_IBAR   = int'(REG_IBAR);
  localparam int ADDR_IOFF   = int'(REG_IOFF);
  localparam int ADDR_STATUS = int'(REG_STATUS);
  // Context slot of each non-GPR register; slots 0..NUM_GPR-1 are the GPRs.
  localparam int SLOT_ACC    = NUM_GPR;
  localparam int SLOT_DBAR   = NUM_GPR + 1;
  localparam int SLOT_DOFF   = NUM_GPR + 2;
  localparam int SLOT_IBAR   = NUM_GPR + 3;
  localparam int SLOT_IOFF   = NUM_GPR + 4;
  localparam int SLOT_STATUS = NUM_GPR + 5;

  logic [DATA_W-1:0] gpr_q    [NUM_GPR];
  logic [DATA_W-1:0] gpr_d    [NUM_GPR];
  logic [DATA_W-1:0] shadow_q [CTX_LEN];
  logic [DATA_W-1:0] shadow_d [CTX_LEN];
  logic [DATA_W-1:0] ctx_live [CTX_LEN];
  logic [DATA_W-1:0] reg_view [NUM_ADDR];
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] restore_val;

  ctx_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic             ctx_busy_q;
  logic             ctx_done_q;
  logic             idle;

  logic [DB_W-1:0]   dbar, dbar_wdata;
  logic [DATA_W-1:0] doff, doff_wdata;
  logic [IB_W-1:0]   ibar, ibar_wdata;
  logic [DATA_W-1:0] ioff, ioff_wdata;
  logic              dbar_load, doff_load, ibar_load, ioff_load;

  logic put_ok;
  logic bypass_a, bypass_b;

  function automatic logic is_writable(input logic [REG_ADDR_WIDTH-1:0] addr);
    return (int'(addr) < NUM_GPR) ||
           ((int'(addr) >= ADDR_DBAR) && (int'(addr) <= ADDR_STATUS));
  endfunction

  assign idle = (state_q == CTX_IDLE);

  // Live register values in context order; base registers zero-extended.
  generate
    for (genvar gi = 0; gi < NUM_GPR; gi++) begin : g_ctx_gpr
      assign ctx_live[gi] = gpr_q[gi];
    end
  endgenerate
  assign ctx_live[SLOT_ACC]    = acc_q;
  assign ctx_live[SLOT_DBAR]   = DATA_W'(dbar);
  assign ctx_live[SLOT_DOFF]   = doff;
  assign ctx_live[SLOT_IBAR]   = DATA_W'(ibar);
  assign ctx_live[SLOT_IOFF]   = ioff;
  assign ctx_live[SLOT_STATUS] = status_q;

  generate
    for (genvar gi = 0; gi < NUM_ADDR; gi++) begin : g_view
      if (gi < NUM_GPR) begin : g_gpr
        assign reg_view[gi] = ctx_live[gi];
      end else if ((gi >= ADDR_ACC) && (gi <= ADDR_STATUS)) begin : g_special
        assign reg_view[gi] = ctx_live[NUM_GPR + gi - ADDR_ACC];
      end else begin : g_unmapped
        assign reg_view[gi] = '0;
      end
    end
  endgenerate

  assign put_ok    = is_writable(put_addr);
  assign bypass_a  = idle && put_enable && put_ok && (put_addr == rd_addr_a);
  assign bypass_b  = idle && put_enable && put_ok && (put_addr == rd_addr_b);
  assign rd_data_a = bypass_a ? acc_q : reg_view[rd_addr_a];
  assign rd_data_b = bypass_b ? acc_q : reg_view[rd_addr_b];

  always_comb begin
    gpr_d       = gpr_q;
    shadow_d    = shadow_q;
    acc_d       = acc_q;
    status_d    = status_q;
    dbar_load   = 1'b0;
    doff_load   = 1'b0;
    ibar_load   = 1'b0;
    ioff_load   = 1'b0;
    dbar_wdata  = acc_q[DB_W-1:0];
    doff_wdata  = acc_q;
    ibar_wdata  = acc_q[IB_W-1:0];
    ioff_wdata  = acc_q;
    restore_val = '0;
    for (int i = 0; i < CTX_LEN; i++) begin
      if (idx_q == IDX_W'(i)) restore_val = shadow_q[i];
    end

    case (state_q)
      CTX_SAVE: begin
        for (int i = 0; i < CTX_LEN; i++) begin
          if (idx_q == IDX_W'(i)) shadow_d[i] = ctx_live[i];
        end
      end
      CTX_RESTORE: begin
        for (int i = 0; i < NUM_GPR; i++) begin
          if (idx_q == IDX_W'(i)) gpr_d[i] = restore_val;
        end
        if (idx_q == IDX_W'(SLOT_ACC)) acc_d = restore_val;
        if (idx_q == IDX_W'(SLOT_DBAR)) begin
          dbar_load  = 1'b1;
          dbar_wdata = restore_val[DB_W-1:0];
        end
        if (idx_q == IDX_W'(SLOT_DOFF)) begin
          doff_load  = 1'b1;
          doff_wdata = restore_val;
        end
        if (idx_q == IDX_W'(SLOT_IBAR)) begin
          ibar_load  = 1'b1;
          ibar_wdata = restore_val[IB_W-1:0];
        end
        if (idx_q == IDX_W'(SLOT_IOFF)) begin
          ioff_load  = 1'b1;
          ioff_wdata = restore_val;
        end
        if (idx_q == IDX_W'(SLOT_STATUS)) status_d = restore_val;
      end
      default: begin
        if (acc_write_enable) acc_d = acc_src_sel ? rd_data_b : acc_in;
        if (put_enable && put_ok) begin
          for (int i = 0; i < NUM_GPR; i++) begin
            if (put_addr == REG_ADDR_WIDTH'(i)) gpr_d[i] = acc_q;
          end
          dbar_load = (put_addr == REG_ADDR_WIDTH'(ADDR_DBAR));
          doff_load = (put_addr == REG_ADDR_WIDTH'(ADDR_DOFF));
          ibar_load = (put_addr == REG_ADDR_WIDTH'(ADDR_IBAR));
          ioff_load = (put_addr == REG_ADDR_WIDTH'(ADDR_IOFF));
          if (put_addr == REG_ADDR_WIDTH'(ADDR_STATUS)) begin
            status_d[DATA_W-1:4] = acc_q[DATA_W-1:4];
          end
        end
        // Flags are applied last so they win bits 3:0 over a same-cycle PUT.
        if (status_write_enable) status_d[OVERFLOW_FLAG:ZERO_FLAG] = flags_in;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      for (int i = 0; i < CTX_LEN; i++) shadow_q[i] <= '0;
      acc_q    <= '0;
      status_q <= '0;
    end else begin
      gpr_q    <= gpr_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CTX_IDLE;
      idx_q      <= '0;
      ctx_busy_q <= 1'b0;
      ctx_done_q <= 1'b0;
    end else begin
      case (state_q)
        CTX_IDLE: begin
          ctx_done_q <= 1'b0;
          idx_q      <= '0;
          if (ctx_save) begin
            state_q    <= CTX_SAVE;
            ctx_busy_q <= 1'b1;
          end else if (ctx_restore) begin
            state_q    <= CTX_RESTORE;
            ctx_busy_q <= 1'b1;
          end
        end
        default: begin
          if (idx_q == IDX_W'(CTX_LEN - 1)) begin
            state_q    <= CTX_IDLE;
            idx_q      <= '0;
            ctx_busy_q <= 1'b0;
            ctx_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

  addr_pointer #(
    .BASE_W(DB_W),
    .OFF_W (DATA_W)
  ) u_dmar (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_base_i(dbar_load),
    .base_i     (dbar_wdata),
    .load_off_i (doff_load),
    .off_i      (doff_wdata),
    .inc_i      (dmar_inc && idle),
    .dec_i      (dmar_dec && idle),
    .base_o     (dbar),
    .off_o      (doff)
  );

  addr_pointer #(
    .BASE_W(IB_W),
    .OFF_W (DATA_W)
  ) u_imar (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_base_i(ibar_load),
    .base_i     (ibar_wdata),
    .load_off_i (ioff_load),
    .off_i      (ioff_wdata),
    .inc_i      (imar_inc && idle),
    .dec_i      (1'b0),
    .base_o     (ibar),
    .off_o      (ioff)
  );

  assign acc_out  = acc_q;
  assign ctx_busy = ctx_busy_q;
  assign ctx_done = ctx_done_q;
  assign dmar     = {dbar, doff};
  assign imar     = {ibar, ioff};

endmodule

// File: tb/tb_context_register_file.sv
// Self-checking bench for context_register_file: per-feature test tasks with a
// queue scoreboard of expected register values.
module tb_context_register_file;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  acc_out, acc_in;
  logic        acc_src_sel, acc_write_enable, put_enable;
  logic [3:0]  put_addr, rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a, rd_data_b;
  logic        status_write_enable;
  logic [3:0]  flags_in;
  logic        dmar_inc, dmar_dec, imar_inc, ctx_save, ctx_restore;
  logic        ctx_busy, ctx_done;
  logic [11:0] dmar, imar;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] rd_v;
  int         n;
  logic       done_seen;

  context_register_file #(
    .DATA_W(8), .I_ADDR_WIDTH(12), .D_ADDR_WIDTH(12), .NUM_GPR(8), .REG_ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .acc_out(acc_out), .acc_in(acc_in),
    .acc_src_sel(acc_src_sel), .acc_write_enable(acc_write_enable),
    .put_enable(put_enable), .put_addr(put_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .status_write_enable(status_write_enable), .flags_in(flags_in),
    .dmar_inc(dmar_inc), .dmar_dec(dmar_dec), .imar_inc(imar_inc),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .ctx_busy(ctx_busy), .ctx_done(ctx_done), .dmar(dmar), .imar(imar)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    acc_in = '0; acc_src_sel = 0; acc_write_enable = 0; put_enable = 0; put_addr = '0;
    status_write_enable = 0; flags_in = '0; dmar_inc = 0; dmar_dec = 0; imar_inc = 0;
    ctx_save = 0; ctx_restore = 0;
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [7:0] v);
    acc_in = v; acc_write_enable = 1; tick(); acc_write_enable = 0;
    put_enable = 1; put_addr = a; tick(); put_enable = 0;
  endtask

  task automatic read_a(input logic [3:0] a, output logic [7:0] d);
    rd_addr_a = a; #1; d = rd_data_a;
  endtask

  task automatic run_ctx(input logic s, input logic r, output int cycles, output logic done_o);
    ctx_save = s; ctx_restore = r; tick(); ctx_save = 0; ctx_restore = 0;
    cycles = 0;
    while (ctx_busy && cycles < 100) begin cycles++; tick(); end
    done_o = ctx_done;
    $display("ctx op save=%0b restore=%0b busy_cycles=%0d done=%0b", s, r, cycles, done_o);
    tick();
  endtask

  task automatic test_reset();
    reset_n = 0; clear_inputs(); rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) tick();
    reset_n = 1; tick();
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a); #1;
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_a !== exp_v) begin errors++; $display("FAIL reset_rd_a[%0d] got=%h exp=%h", a, rd_data_a, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_b !== exp_v) begin errors++; $display("FAIL reset_rd_b[%0d] got=%h exp=%h", 15 - a, rd_data_b, exp_v); end
    end
    checks++; if (dmar !== 12'h000) begin errors++; $display("FAIL reset_dmar got=%h exp=000", dmar); end
    checks++; if (imar !== 12'h000) begin errors++; $display("FAIL reset_imar got=%h exp=000", imar); end
    checks++; if (ctx_busy !== 1'b0 || ctx_done !== 1'b0) begin errors++; $display("FAIL reset_ctx busy=%b done=%b exp=0/0", ctx_busy, ctx_done); end
    $display("test_reset done");
  endtask

  task automatic test_put_bypass();
    acc_in = 8'h5A; acc_write_enable = 1; tick(); acc_write_enable = 0;
    checks++; if (acc_out !== 8'h5A) begin errors++; $display("FAIL acc_write got=%h exp=5a", acc_out); end
    put_enable = 1; put_addr = 4'd3; rd_addr_a = 4'd3; rd_addr_b = 4'd4; #1;
    checks++; if (rd_data_a !== 8'h5A) begin errors++; $display("FAIL bypass_a got=%h exp=5a", rd_data_a); end
    checks++; if (rd_data_b !== 8'h00) begin errors++; $display("FAIL no_bypass_b got=%h exp=00", rd_data_b); end
    tick(); put_enable = 0; #1;
    checks++; if (rd_data_a !== 8'h5A) begin errors++; $display("FAIL put_r3 got=%h exp=5a", rd_data_a); end
    put_enable = 1; put_addr = 4'd8; tick(); put_addr = 4'd14; tick(); put_enable = 0;
    checks++; if (acc_out !== 8'h5A) begin errors++; $display("FAIL put_acc_noop got=%h exp=5a", acc_out); end
    read_a(4'd14, rd_v);
    checks++; if (rd_v !== 8'h00) begin errors++; $display("FAIL unmapped_14 got=%h exp=00", rd_v); end
    acc_in = 8'h11; acc_write_enable = 1; tick();
    acc_src_sel = 1; rd_addr_b = 4'd3; tick(); acc_write_enable = 0; acc_src_sel = 0;
    checks++; if (acc_out !== 8'h5A) begin errors++; $display("FAIL acc_from_rdb got=%h exp=5a", acc_out); end
    $display("test_put_bypass done");
  endtask

  task automatic test_pointers();
    set_reg(4'd9, 8'h00); set_reg(4'd10, 8'hFF);
    dmar_inc = 1; tick(); dmar_inc = 0;
    checks++; if (dmar !== 12'h100) begin errors++; $display("FAIL dmar_carry got=%h exp=100", dmar); end
    read_a(4'd9, rd_v);
    checks++; if (rd_v !== 8'h01) begin errors++; $display("FAIL dbar_read got=%h exp=01", rd_v); end
    set_reg(4'd9, 8'h0F); set_reg(4'd10, 8'hFF);
    dmar_inc = 1; tick(); dmar_inc = 0;
    checks++; if (dmar !== 12'h000) begin errors++; $display("FAIL dmar_wrap_inc got=%h exp=000", dmar); end
    dmar_dec = 1; tick(); dmar_dec = 0;
    checks++; if (dmar !== 12'hFFF) begin errors++; $display("FAIL dmar_wrap_dec got=%h exp=fff", dmar); end
    dmar_inc = 1; dmar_dec = 1; tick(); dmar_inc = 0; dmar_dec = 0;
    checks++; if (dmar !== 12'hFFF) begin errors++; $display("FAIL dmar_both_noop got=%h exp=fff", dmar); end
    set_reg(4'd9, 8'hA0);
    read_a(4'd9, rd_v);
    checks++; if (rd_v !== 8'h00) begin errors++; $display("FAIL dbar_trunc got=%h exp=00", rd_v); end
    acc_in = 8'h10; acc_write_enable = 1; tick(); acc_write_enable = 0;
    put_enable = 1; put_addr = 4'd10; dmar_inc = 1; tick(); put_enable = 0; dmar_inc = 0;
    checks++; if (dmar !== 12'h010) begin errors++; $display("FAIL dmar_put_wins got=%h exp=010", dmar); end
    set_reg(4'd11, 8'h03); set_reg(4'd12, 8'hFF);
    imar_inc = 1; tick(); imar_inc = 0;
    checks++; if (imar !== 12'h400) begin errors++; $display("FAIL imar_carry got=%h exp=400", imar); end
    set_reg(4'd11, 8'h0F); set_reg(4'd12, 8'hFF);
    imar_inc = 1; tick(); imar_inc = 0;
    checks++; if (imar !== 12'h000) begin errors++; $display("FAIL imar_wrap got=%h exp=000", imar); end
    $display("test_pointers done");
  endtask

  task automatic test_status();
    acc_in = 8'hF5; acc_write_enable = 1; tick(); acc_write_enable = 0;
    status_write_enable = 1; flags_in = 4'b1010; put_enable = 1; put_addr = 4'd13; tick();
    status_write_enable = 0; put_enable = 0;
    read_a(4'd13, rd_v);
    checks++; if (rd_v !== 8'hFA) begin errors++; $display("FAIL status_merge got=%h exp=fa", rd_v); end
    status_write_enable = 1; flags_in = 4'b0101; tick(); status_write_enable = 0;
    read_a(4'd13, rd_v);
    checks++; if (rd_v !== 8'hF5) begin errors++; $display("FAIL status_flags got=%h exp=f5", rd_v); end
    set_reg(4'd13, 8'h3C);
    read_a(4'd13, rd_v);
    checks++; if (rd_v !== 8'h35) begin errors++; $display("FAIL status_put got=%h exp=35", rd_v); end
    $display("test_status done");
  endtask

  task automatic test_context();
    logic [7:0] vals [14];
    for (int i = 0; i < 8; i++) vals[i] = 8'(i + 1);
    vals[8] = 8'h33; vals[9] = 8'h02; vals[10] = 8'h34;
    vals[11] = 8'h05; vals[12] = 8'h67; vals[13] = 8'h9C;
    for (int i = 0; i < 8; i++) set_reg(4'(i), vals[i]);
    for (int i = 9; i < 13; i++) set_reg(4'(i), vals[i]);
    acc_in = 8'h90; acc_write_enable = 1; tick(); acc_write_enable = 0;
    put_enable = 1; put_addr = 4'd13; status_write_enable = 1; flags_in = 4'hC; tick(); clear_inputs();
    acc_in = 8'h33; acc_write_enable = 1; tick(); acc_write_enable = 0;
    for (int i = 0; i < 14; i++) exp_q.push_back(vals[i]);

    ctx_save = 1; tick(); ctx_save = 0;
    checks++; if (ctx_busy !== 1'b1) begin errors++; $display("FAIL save_busy_start got=%b exp=1", ctx_busy); end
    n = 0;
    while (ctx_busy && n < 100) begin
      if (n == 2) begin
        put_enable = 1; put_addr = 4'd0; acc_write_enable = 1; acc_in = 8'h77;
        status_write_enable = 1; flags_in = 4'h0; dmar_inc = 1; imar_inc = 1;
      end
      n++; tick();
      clear_inputs();
    end
    $display("ctx op save=1 restore=0 busy_cycles=%0d done=%0b", n, ctx_done);
    checks++; if (n !== 14) begin errors++; $display("FAIL save_busy_len got=%0d exp=14", n); end
    checks++; if (ctx_done !== 1'b1) begin errors++; $display("FAIL save_done got=%b exp=1", ctx_done); end
    tick();
    checks++; if (ctx_done !== 1'b0) begin errors++; $display("FAIL save_done_pulse got=%b exp=0", ctx_done); end
    read_a(4'd0, rd_v);
    checks++; if (rd_v !== 8'h01 || acc_out !== 8'h33) begin errors++; $display("FAIL busy_writes_ignored r0=%h acc=%h exp=01/33", rd_v, acc_out); end

    for (int i = 0; i < 14; i++) if (i != 8) set_reg(4'(i), 8'(8'hC0 + i));
    acc_in = 8'hEE; acc_write_enable = 1; tick(); acc_write_enable = 0;
    read_a(4'd0, rd_v);
    checks++; if (rd_v !== 8'hC0 || acc_out !== 8'hEE) begin errors++; $display("FAIL overwrite r0=%h acc=%h exp=c0/ee", rd_v, acc_out); end

    run_ctx(1'b0, 1'b1, n, done_seen);
    checks++; if (n !== 14 || done_seen !== 1'b1) begin errors++; $display("FAIL restore_seq cycles=%0d done=%b exp=14/1", n, done_seen); end
    for (int i = 0; i < 14; i++) begin
      read_a(4'(i), rd_v);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_v !== exp_v) begin errors++; $display("FAIL restore_reg[%0d] got=%h exp=%h", i, rd_v, exp_v); end
    end
    checks++; if (dmar !== 12'h234 || imar !== 12'h567) begin errors++; $display("FAIL restore_ptrs dmar=%h imar=%h exp=234/567", dmar, imar); end
    $display("test_context done");
  endtask

  task automatic test_reset_mid_restore();
    int dones;
    ctx_restore = 1; tick(); ctx_restore = 0;
    repeat (5) tick();
    reset_n = 0; #2;
    checks++; if (ctx_busy !== 1'b0 || ctx_done !== 1'b0) begin errors++; $display("FAIL midreset_ctx busy=%b done=%b exp=0/0", ctx_busy, ctx_done); end
    checks++; if (acc_out !== 8'h00 || dmar !== 12'h000 || imar !== 12'h000) begin errors++; $display("FAIL midreset_regs acc=%h dmar=%h imar=%h exp=0", acc_out, dmar, imar); end
    for (int a = 0; a < 16; a++) begin
      read_a(4'(a), rd_v); checks++;
      if (rd_v !== 8'h00) begin errors++; $display("FAIL midreset_rd[%0d] got=%h exp=00", a, rd_v); end
    end
    reset_n = 1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (ctx_done) dones++; end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
    set_reg(4'd0, 8'h44);
    run_ctx(1'b0, 1'b1, n, done_seen);
    read_a(4'd0, rd_v);
    checks++; if (rd_v !== 8'h00) begin errors++; $display("FAIL shadow_cleared got=%h exp=00", rd_v); end
    $display("test_reset_mid_restore done");
  endtask

  task automatic test_save_priority();
    set_reg(4'd1, 8'h21);
    ctx_save = 1; ctx_restore = 1; tick(); clear_inputs();
    n = 0;
    while (ctx_busy && n < 100) begin
      if (n == 3) ctx_restore = 1;
      n++; tick();
      ctx_restore = 0;
    end
    $display("ctx op save=1 restore=1 busy_cycles=%0d done=%0b", n, ctx_done);
    checks++; if (n !== 14 || ctx_done !== 1'b1) begin errors++; $display("FAIL both_seq cycles=%0d done=%b exp=14/1", n, ctx_done); end
    tick();
    checks++; if (ctx_busy !== 1'b0) begin errors++; $display("FAIL busy_req_ignored busy=%b exp=0", ctx_busy); end
    read_a(4'd1, rd_v);
    checks++; if (rd_v !== 8'h21) begin errors++; $display("FAIL both_live_r1 got=%h exp=21", rd_v); end
    set_reg(4'd1, 8'h99);
    run_ctx(1'b0, 1'b1, n, done_seen);
    read_a(4'd1, rd_v);
    checks++; if (rd_v !== 8'h21) begin errors++; $display("FAIL save_wins_r1 got=%h exp=21", rd_v); end
    $display("test_save_priority done");
  endtask

  initial begin
    clear_inputs();
    rd_addr_a = '0; rd_addr_b = '0;
    test_reset();
    test_put_bypass();
    test_pointers();
    test_status();
    test_context();
    test_reset_mid_restore();
    test_save_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
